mem2_align_stage: RTL and testbench
===================================

MEM2_ALIGN_STAGE -- requirements
Module: mem2_align_stage

Interface
REQ-001 Parameter: DATA_WIDTH, default 64, register/BRAM data width; legal values 32 or 64.
REQ-002 Parameter: REG_INDEX_BITS, default 5, destination register index width.
REQ-003 Parameter: THREAD_INDEX_BITS, default 3, hardware thread index width.
REQ-004 Parameter: BRAM_LATENCY, default 1, cycles from request to valid in_bram_data; legal values 1..4.
REQ-005 Derived: OFF_BITS = log2(DATA_WIDTH/8); THREADS = 2**THREAD_INDEX_BITS.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 in_valid  input  1  request present this cycle.
REQ-009 in_write_back_flag  input  1  result is written to the register file.
REQ-010 in_load_word_flag  input  1  result comes from BRAM (load), else from in_reg_data.
REQ-011 in_load_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-012 in_load_signed  input  1  sign-extend the sub-word load when 1, zero-extend when 0.
REQ-013 in_byte_offset  input  OFF_BITS  byte address within the BRAM word.
REQ-014 in_reg_index  input  REG_INDEX_BITS  destination register.
REQ-015 in_thread_index  input  THREAD_INDEX_BITS  issuing thread.
REQ-016 in_reg_data  input  DATA_WIDTH  ALU result for non-loads.
REQ-017 in_bram_data  input  DATA_WIDTH  BRAM read word, valid BRAM_LATENCY cycles after the request.
REQ-018 in_flush  input  1  kill in-flight entries of thread in_flush_thread.
REQ-019 in_flush_thread  input  THREAD_INDEX_BITS  thread to flush.
REQ-020 out_valid, out_write_back_flag  output  1 each  result present; write-back qualified by out_valid.
REQ-021 out_reg_index, out_thread_index, out_data  output  REG_INDEX_BITS, THREAD_INDEX_BITS, DATA_WIDTH  registered result fields.
REQ-022 out_busy_mask  output  THREADS  bit t = 1 while thread t has an entry in the delay line or output register.

Function
REQ-023 Control fields and in_reg_data, captured on in_valid at cycle T, shall traverse a BRAM_LATENCY-deep delay line, with no stall.
REQ-024 At cycle T+BRAM_LATENCY the head entry shall be combined with in_bram_data and registered; outputs valid in cycle T+BRAM_LATENCY+1 (total latency BRAM_LATENCY+1).
REQ-025 Back-to-back requests shall be accepted every cycle; throughput one per cycle.
REQ-026 Load data: effective size = min(1<<in_load_size, DATA_WIDTH/8) bytes; offset aligned down to size; the selected lane is shifted to bit 0.
REQ-027 Extension: bits above the size filled with lane MSB if in_load_signed, else zeros; full-width load passes unchanged.
REQ-028 Non-load entries shall output the delayed in_reg_data; in_bram_data ignored.
REQ-029 out_write_back_flag = out_valid AND captured write-back flag; fields of invalid entries are don't-care.
REQ-030 Flush: at the edge where in_flush=1, every delay-line and output-register entry whose thread equals in_flush_thread shall be invalidated; other threads unaffected.
REQ-031 Simultaneous in_flush and in_valid for the same thread: the new request shall be accepted, not killed.
REQ-032 out_busy_mask shall be the OR over valid delay-line and output entries, decoded by thread, computed from registered state.

Reset
REQ-033 rst_n low shall immediately clear all valid bits; out_valid, out_write_back_flag, out_busy_mask = 0; out_reg_index, out_thread_index, out_data = 0.
REQ-034 Reset asserted mid-operation shall discard all in-flight entries; none shall emerge after release.

Verification
REQ-035 BRAM_LATENCY=2, load double, bram=0x1122334455667788 -> out_valid at T+3, out_data=0x1122334455667788.
REQ-036 Load byte signed, offset 3, bram=0x00000000_80000000 -> out_data=0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
REQ-037 Load half unsigned, offset 5 (aligned to 4), bram=0xAAAABEEF_00000000 -> out_data=0xBEEF.
REQ-038 Four back-to-back requests threads 0..3, flush thread 2 one cycle later -> outputs for threads 0,1,3 only; busy_mask bit 2 clears next cycle.
REQ-039 Non-load, reg_data=0x5, write-back=1 -> out_data=0x5, out_write_back_flag=1 at T+BRAM_LATENCY+1.
REQ-040 rst_n pulsed low with three entries in flight -> out_valid stays 0 and out_busy_mask=0 until new requests arrive.

Source files
------------

// File: rtl/mem2_align_if.sv
// mem2_align_if
//   Request/result bundle for the mem2 alignment stage.
//   in_*  : request fields from the execute side, the BRAM read word and the
//           per-thread flush command (driven by master, consumed by slave).
//   out_* : registered write-back result and per-thread busy mask
//           (driven by slave, consumed by master).
//   Handshake: in_valid has no ready partner. The stage never stalls, so a
//   request is accepted on every rising edge where in_valid is high, and
//   out_valid is a one-cycle pulse with no back-pressure.
interface mem2_align_if #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3
);
    localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam int THREADS  = 2 ** THREAD_INDEX_BITS;

    logic                         in_valid;
    logic                         in_write_back_flag;
    logic                         in_load_word_flag;
    logic [1:0]                   in_load_size;
    logic                         in_load_signed;
    logic [OFF_BITS-1:0]          in_byte_offset;
    logic [REG_INDEX_BITS-1:0]    in_reg_index;
    logic [THREAD_INDEX_BITS-1:0] in_thread_index;
    logic [DATA_WIDTH-1:0]        in_reg_data;
    logic [DATA_WIDTH-1:0]        in_bram_data;
    logic                         in_flush;
    logic [THREAD_INDEX_BITS-1:0] in_flush_thread;

    logic                         out_valid;
    logic                         out_write_back_flag;
    logic [REG_INDEX_BITS-1:0]    out_reg_index;
    logic [THREAD_INDEX_BITS-1:0] out_thread_index;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [THREADS-1:0]           out_busy_mask;

    modport master (
        output in_valid, in_write_back_flag, in_load_word_flag, in_load_size,
               in_load_signed, in_byte_offset, in_reg_index, in_thread_index,
               in_reg_data, in_bram_data, in_flush, in_flush_thread,
        input  out_valid, out_write_back_flag, out_reg_index, out_thread_index,
               out_data, out_busy_mask
    );

    modport slave (
        input  in_valid, in_write_back_flag, in_load_word_flag, in_load_size,
               in_load_signed, in_byte_offset, in_reg_index, in_thread_index,
               in_reg_data, in_bram_data, in_flush, in_flush_thread,
        output out_valid, out_write_back_flag, out_reg_index, out_thread_index,
               out_data, out_busy_mask
    );
endinterface

// File: rtl/mem2_align_stage.sv
// mem2_align_stage
//   Second memory stage: carries request control fields alongside an
//   outstanding BRAM read, then selects/extends the loaded lane (or passes the
//   ALU result for non-loads) into a registered write-back result.
//   Latency is BRAM_LATENCY+1 cycles, one request per cycle, no stall.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mem2_align_if.slave (request, BRAM word, flush, result, busy mask)
module mem2_align_stage #(
    parameter int DATA_WIDTH        = 64,
    parameter int REG_INDEX_BITS    = 5,
    parameter int THREAD_INDEX_BITS = 3,
    parameter int BRAM_LATENCY      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem2_align_if.slave  bus
);
    localparam int         OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam int         THREADS  = 2 ** THREAD_INDEX_BITS;
    // Largest log2(bytes) a load can actually use at this data width.
    localparam logic [1:0] MAX_LSZ  = 2'(OFF_BITS);

    typedef struct packed {
        logic                         valid;
        logic                         write_back;
        logic                         load;
        logic [1:0]                   load_size;
        logic                         load_signed;
        logic [OFF_BITS-1:0]          byte_offset;
        logic [REG_INDEX_BITS-1:0]    reg_index;
        logic [THREAD_INDEX_BITS-1:0] thread;
        logic [DATA_WIDTH-1:0]        reg_data;
    } entry_t;

    // stage_q[0] is the newest entry, stage_q[BRAM_LATENCY-1] is the head
    // that lines up with the BRAM word.
    entry_t stage_q [BRAM_LATENCY];
    entry_t stage_d [BRAM_LATENCY];
    entry_t head;

    logic                         out_valid_q,  out_valid_d;
    logic                         out_wb_q,     out_wb_d;
    logic [REG_INDEX_BITS-1:0]    out_reg_q,    out_reg_d;
    logic [THREAD_INDEX_BITS-1:0] out_thread_q, out_thread_d;
    logic [DATA_WIDTH-1:0]        out_data_q,   out_data_d;

    logic [1:0]            eff_lsz;
    logic [OFF_BITS-1:0]   off_mask;
    logic [OFF_BITS-1:0]   aligned_off;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep_mask;
    logic                  lane_msb;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  head_kill;
    logic [THREADS-1:0]    busy_mask;

    assign head = stage_q[BRAM_LATENCY-1];

    // Delay line. A new request is never killed by a same-cycle flush; only
    // entries already held in registers are compared against the flush thread.
    always_comb begin
        stage_d[0].valid       = bus.in_valid;
        stage_d[0].write_back  = bus.in_write_back_flag;
        stage_d[0].load        = bus.in_load_word_flag;
        stage_d[0].load_size   = bus.in_load_size;
        stage_d[0].load_signed = bus.in_load_signed;
        stage_d[0].byte_offset = bus.in_byte_offset;
        stage_d[0].reg_index   = bus.in_reg_index;
        stage_d[0].thread      = bus.in_thread_index;
        stage_d[0].reg_data    = bus.in_reg_data;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            stage_d[i]       = stage_q[i-1];
            stage_d[i].valid = stage_q[i-1].valid &&
                               !(bus.in_flush && (stage_q[i-1].thread == bus.in_flush_thread));
        end
    end

    // Lane select and extension for the head entry.
    always_comb begin
        eff_lsz     = (head.load_size > MAX_LSZ) ? MAX_LSZ : head.load_size;
        // Clears the low eff_lsz offset bits; wraps to zero for full width.
        off_mask    = ~((OFF_BITS'(1) << eff_lsz) - OFF_BITS'(1));
        aligned_off = head.byte_offset & off_mask;
        shifted     = bus.in_bram_data >> {aligned_off, 3'b000};
        keep_mask   = '1;
        lane_msb    = shifted[DATA_WIDTH-1];
        case (eff_lsz)
            2'd0: begin keep_mask = DATA_WIDTH'(8'hFF);         lane_msb = shifted[7];  end
            2'd1: begin keep_mask = DATA_WIDTH'(16'hFFFF);      lane_msb = shifted[15]; end
            2'd2: begin keep_mask = DATA_WIDTH'(32'hFFFF_FFFF); lane_msb = shifted[31]; end
            default: begin keep_mask = '1; lane_msb = shifted[DATA_WIDTH-1]; end
        endcase
        load_data = (shifted & keep_mask) |
                    ({DATA_WIDTH{head.load_signed & lane_msb}} & ~keep_mask);
    end

    // Output register reloads from the head every cycle, so an output entry
    // of a flushed thread is always replaced on the flush edge.
    always_comb begin
        head_kill    = bus.in_flush && (head.thread == bus.in_flush_thread);
        out_valid_d  = head.valid && !head_kill;
        out_wb_d     = head.valid && !head_kill && head.write_back;
        out_reg_d    = head.reg_index;
        out_thread_d = head.thread;
        out_data_d   = head.load ? load_data : head.reg_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_wb_q     <= 1'b0;
            out_reg_q    <= '0;
            out_thread_q <= '0;
            out_data_q   <= '0;
        end else begin
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            out_valid_q  <= out_valid_d;
            out_wb_q     <= out_wb_d;
            out_reg_q    <= out_reg_d;
            out_thread_q <= out_thread_d;
            out_data_q   <= out_data_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            if (stage_q[i].valid) begin
                busy_mask[stage_q[i].thread] = 1'b1;
            end
        end
        if (out_valid_q) begin
            busy_mask[out_thread_q] = 1'b1;
        end
    end

    assign bus.out_valid           = out_valid_q;
    assign bus.out_write_back_flag = out_wb_q;
    assign bus.out_reg_index       = out_reg_q;
    assign bus.out_thread_index    = out_thread_q;
    assign bus.out_data            = out_data_q;
    assign bus.out_busy_mask       = busy_mask;
endmodule

// File: tb/tb_mem2_align_stage.sv
module tb_mem2_align_stage;
  localparam int DW  = 64;
  localparam int RB  = 5;
  localparam int TB  = 3;
  localparam int LAT = 2;
  localparam int EW  = 16 + 1 + RB + TB + DW;

  typedef struct {
    logic          wb;
    logic          load;
    logic [1:0]    size;
    logic          sgn;
    logic [2:0]    off;
    logic [RB-1:0] reg_idx;
    logic [TB-1:0] thr;
    logic [DW-1:0] reg_data;
    logic [DW-1:0] bram;
    logic [DW-1:0] exp_data;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [15:0]   cyc;
  logic          mon_en;
  logic [DW-1:0] bram_req;
  logic [DW-1:0] bram_sr0;
  logic [DW-1:0] bram_sr1;
  logic [EW-1:0] exp_q[$];
  int            n_checks;
  int            n_pass;
  vec_t          vecs[14];

  mem2_align_if #(.DATA_WIDTH(DW), .REG_INDEX_BITS(RB), .THREAD_INDEX_BITS(TB)) bus ();

  mem2_align_stage #(
    .DATA_WIDTH(DW), .REG_INDEX_BITS(RB), .THREAD_INDEX_BITS(TB), .BRAM_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset / BRAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // BRAM word appears LAT cycles after the request that asked for it.
  always @(posedge clk) begin
    bram_sr0 <= bram_req;
    bram_sr1 <= bram_sr0;
  end
  assign bus.in_bram_data = bram_sr1;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: each expected result carries the cycle it must appear in;
  // every other cycle must show out_valid low.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0][EW-1 -: 16] == cyc) begin
        e = exp_q.pop_front();
        check("out_valid", 64'(bus.out_valid), 64'd1);
        check("out_data", bus.out_data, e[DW-1:0]);
        check("out_wb", 64'(bus.out_write_back_flag), 64'(e[DW+TB+RB]));
        check("out_reg_thr", 64'({bus.out_reg_index, bus.out_thread_index}),
              64'(e[DW+TB+RB-1:DW]));
      end else begin
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input vec_t v, input bit push);
    @(posedge clk); #1;
    bus.in_valid           = 1'b1;
    bus.in_write_back_flag = v.wb;
    bus.in_load_word_flag  = v.load;
    bus.in_load_size       = v.size;
    bus.in_load_signed     = v.sgn;
    bus.in_byte_offset     = v.off;
    bus.in_reg_index       = v.reg_idx;
    bus.in_thread_index    = v.thr;
    bus.in_reg_data        = v.reg_data;
    bus.in_flush           = 1'b0;
    bus.in_flush_thread    = '0;
    bram_req               = v.bram;
    if (push) exp_q.push_back({cyc + 16'd3, v.wb, v.reg_idx, v.thr, v.exp_data});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_flush = 1'b0;
      bram_req     = {$urandom(), $urandom()};
    end
  endtask

  function automatic vec_t thr_vec(input logic [TB-1:0] t, input logic [RB-1:0] r,
                                   input logic [DW-1:0] d);
    vec_t v;
    v = '{1'b1, 1'b0, 2'd0, 1'b0, 3'd0, r, t, d, 64'hDEAD_BEEF_DEAD_BEEF, d};
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    bram_req = '0;
    bus.in_valid = 1'b0; bus.in_write_back_flag = 1'b0; bus.in_load_word_flag = 1'b0;
    bus.in_load_size = '0; bus.in_load_signed = 1'b0; bus.in_byte_offset = '0;
    bus.in_reg_index = '0; bus.in_thread_index = '0; bus.in_reg_data = '0;
    bus.in_flush = 1'b0; bus.in_flush_thread = '0;

    //          wb    load  size  sgn   off   reg    thr   reg_data               bram                   expected
    vecs[0]  = '{1'b1, 1'b1, 2'd3, 1'b0, 3'd0, 5'd1,  3'd0, 64'h0,                 64'h1122334455667788, 64'h1122334455667788};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd3, 5'd2,  3'd1, 64'h0,                 64'h0000000080000000, 64'hFFFFFFFFFFFFFF80};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 3'd3, 5'd3,  3'd2, 64'h0,                 64'h0000000080000000, 64'h0000000000000080};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 3'd5, 5'd4,  3'd3, 64'h0,                 64'hAAAABEEF00000000, 64'h000000000000BEEF};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 5'd5,  3'd4, 64'h5,                 64'hDEADBEEFDEADBEEF, 64'h0000000000000005};
    vecs[5]  = '{1'b1, 1'b1, 2'd2, 1'b1, 3'd6, 5'd6,  3'd5, 64'h0,                 64'h8765432100000000, 64'hFFFFFFFF87654321};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 3'd0, 5'd7,  3'd6, 64'h0,                 64'h123456789ABCDEF0, 64'h000000009ABCDEF0};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 5'd8,  3'd7, 64'h0,                 64'h0000000080010000, 64'hFFFFFFFFFFFF8001};
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 1'b1, 3'd6, 5'd9,  3'd0, 64'h0,                 64'h7FFF000000000000, 64'h0000000000007FFF};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 1'b0, 3'd7, 5'd10, 3'd1, 64'h0,                 64'hFE00000000000000, 64'h00000000000000FE};
    vecs[10] = '{1'b1, 1'b1, 2'd3, 1'b1, 3'd5, 5'd11, 3'd2, 64'h0,                 64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    vecs[11] = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd0, 5'd12, 3'd3, 64'h0,                 64'hFFFFFFFFFFFFFF7F, 64'h000000000000007F};
    vecs[12] = '{1'b0, 1'b0, 2'd3, 1'b1, 3'd4, 5'd13, 3'd4, 64'hCAFEF00D12345678,  64'h0123456789ABCDEF, 64'hCAFEF00D12345678};
    vecs[13] = '{1'b1, 1'b1, 2'd0, 1'b1, 3'd1, 5'd31, 3'd7, 64'h0,                 64'h000000000000A500, 64'hFFFFFFFFFFFFFFA5};

    // Reset state.
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_wb", 64'(bus.out_write_back_flag), 64'd0);
    check("rst_busy_mask", 64'(bus.out_busy_mask), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_reg_thr", 64'({bus.out_reg_index, bus.out_thread_index}), 64'd0);
    #21 rst_n = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Isolated requests: exact latency, surrounded by idle cycles.
    for (int i = 0; i < 14; i++) begin
      drive_req(vecs[i], 1'b1);
      idle(3);
    end

    // Same vectors back-to-back.
    for (int i = 0; i < 14; i++) drive_req(vecs[i], 1'b1);
    idle(4);

    // Threads 0..3 back-to-back, flush thread 2 in the cycle after its request.
    drive_req(thr_vec(3'd0, 5'd20, 64'h100), 1'b1);
    drive_req(thr_vec(3'd1, 5'd21, 64'h101), 1'b1);
    drive_req(thr_vec(3'd2, 5'd22, 64'h102), 1'b0);
    drive_req(thr_vec(3'd3, 5'd23, 64'h103), 1'b1);
    bus.in_flush = 1'b1;
    bus.in_flush_thread = 3'd2;
    check("flush_busy_before", 64'(bus.out_busy_mask), 64'h07);
    idle(1);
    check("flush_busy_after", 64'(bus.out_busy_mask), 64'h0A);
    idle(4);

    // Flush and new request for the same thread in one cycle: older entry
    // dies, the new one survives; another thread is untouched.
    drive_req(thr_vec(3'd6, 5'd24, 64'h200), 1'b1);
    drive_req(thr_vec(3'd5, 5'd25, 64'h201), 1'b0);
    drive_req(thr_vec(3'd5, 5'd26, 64'h202), 1'b1);
    bus.in_flush = 1'b1;
    bus.in_flush_thread = 3'd5;
    check("same_thr_busy_0", 64'(bus.out_busy_mask), 64'h60);
    idle(1);
    check("same_thr_busy_1", 64'(bus.out_busy_mask), 64'h60);
    idle(1);
    check("same_thr_busy_2", 64'(bus.out_busy_mask), 64'h20);
    idle(4);

    // Reset pulse with three entries in flight.
    drive_req(thr_vec(3'd1, 5'd27, 64'h300), 1'b0);
    drive_req(thr_vec(3'd4, 5'd28, 64'h301), 1'b0);
    drive_req(thr_vec(3'd7, 5'd29, 64'h302), 1'b0);
    idle(1);
    check("inflight_busy", 64'(bus.out_busy_mask), 64'h92);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_busy", 64'(bus.out_busy_mask), 64'd0);
    check("midrst_out_data", bus.out_data, 64'd0);
    idle(2);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("post_rst_busy", 64'(bus.out_busy_mask), 64'd0);
    end

    // Recovery after reset.
    drive_req(vecs[4], 1'b1);
    drive_req(vecs[1], 1'b1);
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
